// File: rtl/int_src_if.sv
// rtl/int_src_if.sv - config register port and interrupt request/ack handshake
// Groups the software config bus and the controller-facing request outputs.
interface int_src_if;
   logic        cfg_we;
   logic [1:0]  cfg_addr;
   logic [15:0] cfg_wdata;
   logic [15:0] cfg_rdata;
   logic        int_ack;
   logic [2:0]  int_priority;
   logic [7:0]  int_vec;
   logic        int_valid;

   modport master (
      output cfg_we, cfg_addr, cfg_wdata, int_ack,
      input  cfg_rdata, int_priority, int_vec, int_valid
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_wdata, int_ack,
      output cfg_rdata, int_priority, int_vec, int_valid
   );
endinterface

// File: rtl/int_src.sv
// rtl/int_src.sv - LC-3 interrupt source: edge latch, interval timer, priority arbiter
// Presents one winner to the controller and holds it until acknowledged.
module int_src #(
   parameter logic [7:0] VEC_BASE = 8'h80
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  irq_in,
   int_src_if.slave    bus
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PRESENT = 2'd1,
      S_ACKED   = 2'd2
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [2:0]  r_irq_q;
   logic [3:0]  r_pending;
   logic [3:0]  r_enable;
   logic [11:0] r_prio;
   logic [15:0] r_reload;
   logic [15:0] r_count;
   logic [1:0]  r_win, w_win_nxt;
   logic [2:0]  r_out_prio, w_out_prio_nxt;
   logic [7:0]  r_out_vec, w_out_vec_nxt;

   logic [2:0]  w_src_prio [4];
   logic [3:0]  w_cand;
   logic [1:0]  w_best_idx;
   logic [2:0]  w_best_prio;
   logic        w_any;
   logic        w_timer_exp;
   logic [3:0]  w_set;
   logic [3:0]  w_clr;
   logic [3:0]  w_ack_clr;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_src_prio[i] = r_prio[3*i +: 3];
         w_cand[i]     = r_pending[i] & r_enable[i] & (r_prio[3*i +: 3] != 3'd0);
      end
   end

   // Strict '>' while scanning upward keeps the lower index on a tie.
   always_comb begin
      w_best_idx  = 2'd0;
      w_best_prio = 3'd0;
      w_any       = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (w_cand[i] && (w_src_prio[i] > w_best_prio)) begin
            w_best_idx  = 2'(i);
            w_best_prio = w_src_prio[i];
            w_any       = 1'b1;
         end
      end
   end

   assign w_timer_exp = (r_reload != 16'd0) && (r_count == 16'd0) &&
                        !(bus.cfg_we && bus.cfg_addr == 2'd2);

   always_comb begin
      w_state_nxt    = r_state;
      w_win_nxt      = r_win;
      w_out_prio_nxt = 3'd0;
      w_out_vec_nxt  = 8'd0;
      w_ack_clr      = 4'd0;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_state_nxt    = S_PRESENT;
               w_win_nxt      = w_best_idx;
               w_out_prio_nxt = w_best_prio;
               w_out_vec_nxt  = VEC_BASE + {6'd0, w_best_idx};
            end
         end
         S_PRESENT: begin
            if (bus.int_ack) begin
               w_state_nxt      = S_ACKED;
               w_ack_clr[r_win] = 1'b1;
            end else if (!w_cand[r_win]) begin
               w_state_nxt = S_IDLE;
            end else if (w_best_prio > w_src_prio[r_win]) begin
               w_win_nxt      = w_best_idx;
               w_out_prio_nxt = w_best_prio;
               w_out_vec_nxt  = VEC_BASE + {6'd0, w_best_idx};
            end else begin
               w_out_prio_nxt = w_src_prio[r_win];
               w_out_vec_nxt  = VEC_BASE + {6'd0, r_win};
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Set sources are OR-ed in last so a fresh edge or expiry beats any clear.
   assign w_set = {w_timer_exp, irq_in & ~r_irq_q};
   assign w_clr = w_ack_clr | ((bus.cfg_we && bus.cfg_addr == 2'd3) ? bus.cfg_wdata[3:0] : 4'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_irq_q    <= 3'd0;
         r_pending  <= 4'd0;
         r_enable   <= 4'd0;
         r_prio     <= 12'd0;
         r_reload   <= 16'd0;
         r_count    <= 16'd0;
         r_win      <= 2'd0;
         r_out_prio <= 3'd0;
         r_out_vec  <= 8'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_win      <= w_win_nxt;
         r_out_prio <= w_out_prio_nxt;
         r_out_vec  <= w_out_vec_nxt;
         r_irq_q    <= irq_in;
         r_pending  <= (r_pending & ~w_clr) | w_set;
         if (bus.cfg_we && bus.cfg_addr == 2'd0) r_enable <= bus.cfg_wdata[3:0];
         if (bus.cfg_we && bus.cfg_addr == 2'd1) r_prio   <= bus.cfg_wdata[11:0];
         if (bus.cfg_we && bus.cfg_addr == 2'd2) begin
            r_reload <= bus.cfg_wdata;
            r_count  <= bus.cfg_wdata;
         end else if (r_reload == 16'd0) begin
            r_count <= 16'd0;
         end else if (r_count == 16'd0) begin
            r_count <= r_reload;
         end else begin
            r_count <= r_count - 16'd1;
         end
      end
   end

   always_comb begin
      bus.cfg_rdata = 16'd0;
      case (bus.cfg_addr)
         2'd0:    bus.cfg_rdata = {12'd0, r_enable};
         2'd1:    bus.cfg_rdata = {4'd0, r_prio};
         2'd2:    bus.cfg_rdata = r_reload;
         default: bus.cfg_rdata = {12'd0, r_pending};
      endcase
   end

   assign bus.int_priority = r_out_prio;
   assign bus.int_vec      = r_out_vec;
   assign bus.int_valid    = (r_state == S_PRESENT);

endmodule

// File: doc/int_src.md
# int_src

Interrupt source block for the LC-3 datapath. It is the requesting end of the interrupt interface: it latches device interrupt requests and one internal interval timer. It arbitrates among enabled pending sources by programmable priority, then presents a stable `int_priority`/`int_vec` pair to the interrupt controller until the control FSM acknowledges it. Software configures it through a small register port: enable mask, priorities, timer reload, and write-1-to-clear pending.

## Interface
- `VEC_BASE`, default 8'h80: vector of source 0. Source i uses `VEC_BASE + i` (8-bit, wraps mod 256).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `irq_in`  in  3  level requests from external devices (sources 0..2), rising-edge detected.
- `cfg_we`  in  1  config write strobe, one cycle per write.
- `cfg_addr`  in  2  register select: 0=ENABLE[3:0], 1=PRIO[11:0] (source i at bits [3i+2:3i]), 2=TIMER_RELOAD[15:0], 3=PEND (write-1-to-clear [3:0]).
- `cfg_wdata`  in  16  write data. Unused bits are ignored.
- `cfg_rdata`  out  16  combinational readback of the register at `cfg_addr`, zero-extended. Address 3 returns the `pending` bits.
- `int_ack`  in  1  one-cycle pulse from the control FSM when the vector is taken.
- `int_priority`  out  3  priority of the presented request. It is 0 when nothing is presented.
- `int_vec`  out  8  vector of the presented request. It is 0 when nothing is presented.
- `int_valid`  out  1  high while a request is presented (state PRESENT).

## Operation
- **Sources.** Sources 0..2 are `irq_in[2:0]`. Source 3 is the internal timer.
- **Edge detect.**
  - `irq_q` is `irq_in` registered.
  - `pending[i]` sets at the edge where `irq_in[i]=1` and `irq_q[i]=0`.
  - A held-high level sets `pending[i]` once only.
- **Timer.**
  - A write to TIMER_RELOAD loads both the reload register and the counter.
  - While reload≠0: the counter decrements each cycle. When it reaches 0 it sets `pending[3]` and reloads, giving a period of reload+1 cycles.
  - Reload=0 stops the timer and holds the counter at 0.
- **Candidate.** A source is a candidate when `pending[i] & ENABLE[i] & (PRIO[i]≠0)`. Priority 0 means masked.
- **Arbitration.** The highest PRIO wins. On a tie, the lower index wins.
- **FSM states:** IDLE, PRESENT, ACKED.
- **IDLE.**
  - Outputs are 0.
  - If any candidate exists, latch the winner index and go to PRESENT.
  - `int_ack` is ignored in this state.
- **PRESENT.**
  - `int_priority` = PRIO[winner] and `int_vec` = `VEC_BASE`+winner, both registered and `int_valid`=1.
  - If a candidate with strictly higher priority appears, the winner is replaced at the next edge and the state stays PRESENT.
  - If the winner stops being a candidate (W1C, enable cleared, or PRIO set to 0), go to IDLE with outputs 0 at the next edge.
  - On `int_ack`: clear `pending[winner]` and go to ACKED.
- **ACKED.** Outputs are 0 for exactly one cycle, then go to IDLE. This lets the controller's priority register update before re-arbitration.
- **Simultaneous events on the same bit.** A new edge or timer expiry wins over a W1C or ack clear, so `pending` stays 1.
- **Ack versus preemption in the same cycle.** Ack wins. The acknowledged source is the winner that was presented during that cycle.
- **PRIO rewrite while PRESENT.** If the winner is still a candidate, `int_priority` follows the new value at the next edge.
- **Reset** (any cycle, including mid-PRESENT):
  - `pending`, ENABLE, PRIO, reload, counter and `irq_q` go to 0, and the state goes to IDLE.
  - `int_priority`=0, `int_vec`=0, `int_valid`=0, `cfg_rdata`=0.

## Timing
- `irq_in` rising edge first sampled at edge E0: `pending` is 1 after E0, and outputs are valid after E1. The latency is 2 cycles.
- Timer expiry sets `pending[3]` at edge T, and outputs are valid after T+1.
- Config writes take effect at the write edge. Arbitration uses the new values at the following edge.
- `int_ack` sampled at edge A: outputs are 0 after A (ACKED), IDLE after A+1, and the next request is presented after A+2 at the earliest.
- Outputs change only at clock edges. There are no combinational paths from `irq_in` or `int_ack` to outputs.

## Test plan
- **Basic request.** Reset, then ENABLE=4'hF, PRIO=12'h004 (src0 = PL4), raise `irq_in[0]`. Required: after 2 edges `int_valid`=1, `int_priority`=4, `int_vec`=8'h80. Pulse `int_ack`: outputs 0 for one cycle, `pending[0]`=0, and no re-request while `irq_in[0]` stays high.
- **Tie and priority.** PRIO src1=3, src2=3, src0=1, with all three edges in the same cycle. Required: vec 8'h81. After ack, vec 8'h82. After ack, vec 8'h80.
- **Preemption.** Src0 at PRIO 2 presented, then src2 raised at PRIO 6 before ack. Required: outputs switch to priority 6, vec 8'h82. Ack clears only `pending[2]`, and src0 is re-presented 2 cycles later.
- **Timer.** TIMER_RELOAD=5, PRIO3=7, ENABLE[3]=1. Required: `pending[3]` sets every 6 cycles and vec 8'h83 is presented. Writing reload 0 produces no further expiries.
- **Retract and collisions.** While src1 is presented, write PEND=4'h2: required IDLE and outputs 0 at the next edge. In the same cycle as the W1C, a new `irq_in[1]` edge: required `pending[1]` stays 1.
- **Reset mid-operation.** Assert `rst` during PRESENT. Required: all outputs 0, `cfg_rdata`=0 for all addresses, and no request after release until a new edge arrives.
